dout_checker: RTL

- Self-checking consumer for an arf output port (dout_req_N / dout_ack_N / dout_N); replaces the plain consumer in simulation benches.
- Drives the req/ack handshake and checks every accepted word against an affine model, expected = scale*k + offset for the k-th word.
- Also injects a deterministic stall pattern, detects timeouts and protocol violations, and raises done/pass for bench termination.

---
 rtl/dout_checker.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dout_checker.sv
// dout_checker: self-checking consumer for an arf output port.
// Drives req, accepts one word per ack and compares each word against the
// affine sequence scale*k + offset. It also inserts a periodic stall, flags
// timeouts and out-of-state acks, and raises done/pass so a bench can stop.
module dout_checker #(
  parameter int data_width    = 32,
  parameter int scale         = 3,
  parameter int offset        = 2,
  parameter int initial_value = 0,
  parameter int max_data_size = 5000,
  parameter int stall_period  = 0,
  parameter int stall_cycles  = 4,
  parameter int timeout       = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req,
  input  logic                  ack,
  input  logic [data_width-1:0] din,
  output logic [31:0]           count,
  output logic [31:0]           err_count,
  output logic [31:0]           first_err_idx,
  output logic [data_width-1:0] first_err_data,
  output logic                  timeout_err,
  output logic                  proto_err,
  output logic                  done,
  output logic                  pass
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STALL, S_DONE} state_t;

  // Model constants reduced to the comparison width so the arithmetic wraps
  // modulo 2^data_width exactly like the producer's datapath.
  localparam logic [data_width-1:0] SCALE_W  = data_width'(scale);
  localparam logic [data_width-1:0] OFFSET_W = data_width'(offset);
  localparam logic [data_width-1:0] INIT_K_W = data_width'(initial_value);
  localparam logic [data_width-1:0] ONE_W    = data_width'(1);
  localparam logic [31:0]           MAX_W    = 32'(max_data_size);
  localparam logic [31:0]           TMO_W    = 32'(timeout);
  localparam logic [31:0]           SPER_W   = 32'(stall_period);
  localparam logic [31:0]           SCYC_W   = 32'(stall_cycles);

  state_t                state_q, state_d;
  logic [data_width-1:0] k_q, k_d;
  logic [31:0]           phase_q, phase_d;      // accepts since the last stall
  logic [31:0]           stall_cnt_q, stall_cnt_d;
  logic [31:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  req_q, req_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           err_count_q, err_count_d;
  logic [31:0]           first_err_idx_q, first_err_idx_d;
  logic [data_width-1:0] first_err_data_q, first_err_data_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  proto_err_q, proto_err_d;
  logic                  done_q, done_d;

  logic [data_width-1:0] expected_w;
  logic [31:0]           count_inc;
  logic [31:0]           phase_inc;
  logic [31:0]           tmo_inc;
  logic                  accept;
  logic                  mismatch;

  assign expected_w = k_q * SCALE_W + OFFSET_W;
  assign count_inc  = count_q + 32'd1;
  assign phase_inc  = phase_q + 32'd1;
  assign tmo_inc    = tmo_cnt_q + 32'd1;
  assign accept     = (state_q == S_REQ) && ack;
  assign mismatch   = accept && (din != expected_w);

  // Next-state and datapath updates; every register holds unless its state acts.
  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    phase_d          = phase_q;
    stall_cnt_d      = stall_cnt_q;
    tmo_cnt_d        = tmo_cnt_q;
    count_d          = count_q;
    err_count_d      = err_count_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;
    timeout_err_d    = timeout_err_q;
    proto_err_d      = proto_err_q;

    case (state_q)
      S_IDLE: begin
        if (ack) proto_err_d = 1'b1;
        state_d = (max_data_size == 0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (ack) begin
          count_d   = count_inc;
          k_d       = k_q + ONE_W;
          tmo_cnt_d = 32'd0;
          if (mismatch) begin
            if (err_count_q != '1) err_count_d = err_count_q + 32'd1;
            // err_count never returns to zero, so zero means no earlier error
            if (err_count_q == 32'd0) begin
              first_err_idx_d  = count_q;
              first_err_data_d = din;
            end
          end
          if (stall_period != 0) begin
            phase_d = (phase_inc == SPER_W) ? 32'd0 : phase_inc;
          end
          if (count_inc == MAX_W) begin
            state_d = S_DONE;
          end else if ((stall_period != 0) && (phase_inc == SPER_W)) begin
            state_d     = S_STALL;
            stall_cnt_d = 32'd0;
          end
        end else begin
          // Counter saturates at the limit; the flag is sticky until reset.
          if (tmo_cnt_q < TMO_W) tmo_cnt_d = tmo_inc;
          if (tmo_inc >= TMO_W) timeout_err_d = 1'b1;
        end
      end
      S_STALL: begin
        if (ack) proto_err_d = 1'b1;
        if (stall_cnt_q + 32'd1 >= SCYC_W) state_d = S_REQ;
        else stall_cnt_d = stall_cnt_q + 32'd1;
      end
      S_DONE: begin
        if (ack) proto_err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // req and done are registered views of the state being entered.
    req_d  = (state_d == S_REQ);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      k_q              <= INIT_K_W;
      phase_q          <= 32'd0;
      stall_cnt_q      <= 32'd0;
      tmo_cnt_q        <= 32'd0;
      req_q            <= 1'b0;
      count_q          <= 32'd0;
      err_count_q      <= 32'd0;
      first_err_idx_q  <= 32'd0;
      first_err_data_q <= '0;
      timeout_err_q    <= 1'b0;
      proto_err_q      <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      phase_q          <= phase_d;
      stall_cnt_q      <= stall_cnt_d;
      tmo_cnt_q        <= tmo_cnt_d;
      req_q            <= req_d;
      count_q          <= count_d;
      err_count_q      <= err_count_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
      timeout_err_q    <= timeout_err_d;
      proto_err_q      <= proto_err_d;
      done_q           <= done_d;
    end
  end

  // Simulation log: one line per wrong word (index, expected, received).
  always_ff @(posedge clk) begin
    if (!rst && mismatch) begin
      $write("dout_checker: word idx=%0d expected=%0d received=%0d\n",
             count_q, expected_w, din);
    end
  end

  assign req            = req_q;
  assign count          = count_q;
  assign err_count      = err_count_q;
  assign first_err_idx  = first_err_idx_q;
  assign first_err_data = first_err_data_q;
  assign timeout_err    = timeout_err_q;
  assign proto_err      = proto_err_q;
  assign done           = done_q;
  assign pass           = done_q && (err_count_q == 32'd0) && !timeout_err_q && !proto_err_q;

endmodule
